// File: rtl/dense_seq_ctrl.sv
// rtl/dense_seq_ctrl.sv - time-multiplexed fully-connected layer sequencer sharing one MAC
// Optional macro DENSE_SEQ_RELU_EN: negative neuron results are written as zero.
module dense_seq_ctrl #(
  parameter int N_IN  = 32,
  parameter int N_OUT = 5,
  parameter int WIDTH = 21,
  parameter int NFRAC = 10,
  parameter int ACC_W = 2*WIDTH + $clog2(N_IN) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*WIDTH-1:0]    in_data,
  output logic [$clog2(N_IN)-1:0]  w_row,
  output logic [$clog2(N_OUT)-1:0] w_col,
  input  logic [WIDTH-1:0]         w_data,
  input  logic [WIDTH-1:0]         b_data,
  input  logic                     abort,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*WIDTH-1:0]   out_data
);
  localparam int RW = $clog2(N_IN);
  localparam int CW = $clog2(N_OUT);
  localparam logic [RW-1:0] I_LAST = RW'(N_IN - 1);
  localparam logic [CW-1:0] J_LAST = CW'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, FIN, OUT} state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [RW-1:0]           i_q, i_d;
  logic [CW-1:0]           j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] x_q [N_IN];
  logic signed [WIDTH-1:0] x_d [N_IN];
  logic signed [WIDTH-1:0] y_q [N_OUT];
  logic signed [WIDTH-1:0] y_d [N_OUT];

  logic signed [WIDTH-1:0]   x_cur;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   scaled;
  logic signed [WIDTH-1:0]   res;

  // Datapath: one product per MAC cycle, bias/rescale/saturate in FIN.
  always_comb begin
    x_cur  = x_q[i_q];
    prod   = $signed({{WIDTH{x_cur[WIDTH-1]}}, x_cur}) *
             $signed({{WIDTH{w_data[WIDTH-1]}}, w_data});
    sum    = acc_q + ({{(ACC_W-WIDTH){b_data[WIDTH-1]}}, b_data} <<< NFRAC);
    scaled = sum >>> NFRAC;
    if (scaled > SAT_MAX) begin
      res = SAT_MAX[WIDTH-1:0];
    end else if (scaled < SAT_MIN) begin
      res = SAT_MIN[WIDTH-1:0];
    end else begin
      res = scaled[WIDTH-1:0];
    end
`ifdef DENSE_SEQ_RELU_EN
    if (res[WIDTH-1]) res = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int k = 0; k < N_IN; k++) x_d[k] = in_data[k*WIDTH +: WIDTH];
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
        if (i_q == I_LAST) state_d = FIN;
        else               i_d = i_q + 1'b1;
      end
      FIN: begin
        y_d[j_q] = res;
        acc_d    = '0;
        if (j_q == J_LAST) begin
          state_d = OUT;
        end else begin
          j_d     = j_q + 1'b1;
          i_d     = '0;
          state_d = MAC;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a pending FIN write or output transfer.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      acc_d   = '0;
      i_d     = i_q;
      j_d     = j_q;
      y_d     = y_q;
    end
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      for (int k = 0; k < N_IN; k++)  x_q[k] <= '0;
      for (int k = 0; k < N_OUT; k++) y_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < N_OUT; k++) out_data[k*WIDTH +: WIDTH] = y_q[k];
  end

  assign in_ready  = in_ready_q;
  assign w_row     = i_q;
  assign w_col     = j_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// tb/tb_dense_seq_ctrl.sv - scoreboard bench for dense_seq_ctrl with a behavioural layer model
module tb_dense_seq_ctrl;
  localparam int N_IN  = 32;
  localparam int N_OUT = 5;
  localparam int WIDTH = 21;
  localparam int NFRAC = 10;
  localparam int RW    = $clog2(N_IN);
  localparam int CW    = $clog2(N_OUT);
  localparam int LAT   = 1 + N_OUT*(N_IN+1);
  localparam longint MAXV = (64'sd1 <<< (WIDTH-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (WIDTH-1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic abort = 1'b0;
  logic out_ready = 1'b0;
  logic [N_IN*WIDTH-1:0] in_data = '0;
  logic in_ready, busy, out_valid;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic [WIDTH-1:0] w_data, b_data;
  logic [N_OUT*WIDTH-1:0] out_data;

  logic [WIDTH-1:0] wmem [N_IN][N_OUT];
  logic [WIDTH-1:0] bmem [N_OUT];
  int bias_tab [N_OUT] = '{-64, -65, -72, 84, 220};
  int row0_tab [N_OUT] = '{-13, 323, -178, 67, -109};

  typedef struct { logic [N_OUT*WIDTH-1:0] data; int due; } sb_t;
  typedef struct { int row; int col; } ad_t;
  sb_t sb_q[$];
  ad_t ad_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  assign w_data = wmem[w_row][w_col];
  assign b_data = bmem[w_col];

  dense_seq_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .WIDTH(WIDTH), .NFRAC(NFRAC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_row(w_row), .w_col(w_col), .w_data(w_data), .b_data(b_data), .abort(abort),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: straight dot products in 64-bit integers, floor rescale, clamp.
  function automatic logic [N_OUT*WIDTH-1:0] model(input logic [N_IN*WIDTH-1:0] v);
    logic [N_OUT*WIDTH-1:0] r;
    longint acc;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc += longint'($signed(v[i*WIDTH +: WIDTH])) * longint'($signed(wmem[i][j]));
      acc += longint'($signed(bmem[j])) * (64'sd1 <<< NFRAC);
      acc = acc >>> NFRAC;
      if (acc > MAXV) acc = MAXV;
      else if (acc < MINV) acc = MINV;
`ifdef DENSE_SEQ_RELU_EN
      if (acc < 0) acc = 0;
`endif
      r[j*WIDTH +: WIDTH] = acc[WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [N_OUT*WIDTH-1:0] pack5(input int a0, a1, a2, a3, a4);
    logic [N_OUT*WIDTH-1:0] r;
    int t [N_OUT];
    t = '{a0, a1, a2, a3, a4};
    r = '0;
    for (int k = 0; k < N_OUT; k++) r[k*WIDTH +: WIDTH] = t[k][WIDTH-1:0];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] rnd(input int span);
    int t;
    if (span <= 0) t = int'($urandom);
    else t = int'($urandom_range(0, 2*span)) - span;
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [N_IN*WIDTH-1:0] rvec(input int span);
    logic [N_IN*WIDTH-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*WIDTH +: WIDTH] = rnd(span);
    return r;
  endfunction

  function automatic logic [N_IN*WIDTH-1:0] cvec(input int val);
    logic [N_IN*WIDTH-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*WIDTH +: WIDTH] = val[WIDTH-1:0];
    return r;
  endfunction

  task automatic rtab(input int span);
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = rnd(span);
    for (int j = 0; j < N_OUT; j++) bmem[j] = rnd(span);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_vec(input logic [N_IN*WIDTH-1:0] v, input logic [N_OUT*WIDTH-1:0] exp);
    int w;
    sb_t e;
    ad_t a;
    w = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && w < 400) begin tick(1); w++; end
    chk("send_in_ready", in_ready, 1'b1);
    if (!in_ready) begin in_valid = 1'b0; return; end
    e.data = exp;
    e.due  = cyc + LAT;
    sb_q.push_back(e);
    tick(1);
    in_valid = 1'b0;
    for (int k = 0; k < N_OUT*(N_IN+1); k++) begin
      a.col = k / (N_IN+1);
      a.row = (k % (N_IN+1) < N_IN) ? k % (N_IN+1) : -1;
      ad_q.push_back(a);
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (sb_q.size() > 0 && w < 400) begin tick(1); w++; end
    chk("drain_timeout", sb_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each output transfer, tracks addresses and stalls.
  initial begin
    bit ov_seen;
    bit rdy_next;
    logic [N_OUT*WIDTH-1:0] held;
    sb_t e;
    ad_t a;
    ov_seen = 0;
    rdy_next = 0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || abort) begin
        sb_q.delete();
        ad_q.delete();
        ov_seen = 0;
        rdy_next = 0;
      end else begin
        if (rdy_next) begin chk("in_ready_after_out", in_ready, 1'b1); rdy_next = 0; end
        if (ad_q.size() > 0) begin
          a = ad_q.pop_front();
          if (a.row >= 0) chk("w_row", w_row, a.row);
          chk("w_col", w_col, a.col);
        end
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: out_valid=1 required 0 (cycle %0d)", cyc);
          end else begin
            if (!ov_seen) begin
              chk("latency", cyc, sb_q[0].due);
              ov_seen = 1;
              held = out_data;
            end else begin
              chk("out_data_stable", out_data, held);
            end
            chk("in_ready_low_in_out", in_ready, 1'b0);
            if (out_ready) begin
              e = sb_q.pop_front();
              chk("out_data", out_data, e.data);
              ov_seen = 0;
              rdy_next = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [N_IN*WIDTH-1:0] v;
    logic [N_OUT*WIDTH-1:0] e, prev, part;
    int w;
    int abort_off;

    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = '0;
    for (int j = 0; j < N_OUT; j++) bmem[j] = bias_tab[j][WIDTH-1:0];

    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_data", out_data, '0);
    chk("post_rst_w_row", w_row, 0);
    chk("post_rst_w_col", w_col, 0);
    chk("post_rst_busy", busy, 1'b0);
    out_ready = 1'b1;

    // Zero vector: bias passes straight through.
`ifdef DENSE_SEQ_RELU_EN
    send_vec('0, pack5(0, 0, 0, 84, 220));
`else
    send_vec('0, pack5(-64, -65, -72, 84, 220));
`endif
    wait_done();

    // x[0] = 1.0 selects row 0 plus bias.
    rtab(2000);
    for (int j = 0; j < N_OUT; j++) begin
      wmem[0][j] = row0_tab[j][WIDTH-1:0];
      bmem[j] = bias_tab[j][WIDTH-1:0];
    end
    v = '0;
    v[0 +: WIDTH] = 21'd1024;
`ifdef DENSE_SEQ_RELU_EN
    send_vec(v, pack5(0, 258, 0, 151, 111));
`else
    send_vec(v, pack5(-77, 258, -250, 151, 111));
`endif
    wait_done();

    // Saturation at both rails.
    for (int i = 0; i < N_IN; i++)
      for (int j = 0; j < N_OUT; j++) wmem[i][j] = 21'd1048575;
    for (int j = 0; j < N_OUT; j++) bmem[j] = '0;
    send_vec(cvec(1048575), pack5(1048575, 1048575, 1048575, 1048575, 1048575));
    wait_done();
`ifdef DENSE_SEQ_RELU_EN
    send_vec(cvec(-1048576), pack5(0, 0, 0, 0, 0));
`else
    send_vec(cvec(-1048576), pack5(-1048576, -1048576, -1048576, -1048576, -1048576));
`endif
    wait_done();

    // Randomised vectors against the model.
    for (int n = 0; n < 6; n++) begin
      rtab((n % 3 == 0) ? 0 : 3000);
      v = rvec((n % 2 == 0) ? 4096 : 0);
      send_vec(v, model(v));
      wait_done();
    end

    // Output stall, then back-to-back acceptance.
    rtab(3000);
    out_ready = 1'b0;
    v = rvec(4096);
    send_vec(v, model(v));
    w = 0;
    while (!out_valid && w < 400) begin tick(1); w++; end
    chk("stall_out_valid", out_valid, 1'b1);
    tick(20);
    out_ready = 1'b1;
    v = rvec(4096);
    e = model(v);
    send_vec(v, e);
    wait_done();

    // Asynchronous reset in the middle of MAC.
    v = rvec(4096);
    send_vec(v, model(v));
    tick(49);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, '0);
    chk("midrst_w_row", w_row, 0);
    chk("midrst_w_col", w_col, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("midrst_in_ready_after", in_ready, 1'b1);
    v = rvec(4096);
    prev = model(v);
    send_vec(v, prev);
    wait_done();

    // Abort mid-vector: finished columns are kept, the rest show the prior vector.
    rtab(3000);
    abort_off = 80;
    v = rvec(4096);
    e = model(v);
    send_vec(v, e);
    tick(abort_off - 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    part = prev;
    for (int j = 0; j < N_OUT; j++)
      if ((N_IN+1)*(j+1) < abort_off) part[j*WIDTH +: WIDTH] = e[j*WIDTH +: WIDTH];
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_out_data", out_data, part);
    tick(200);
    chk("abort_idle_in_ready", in_ready, 1'b1);

    // Abort coinciding with an output handshake cancels the transfer.
    out_ready = 1'b0;
    v = rvec(4096);
    e = model(v);
    send_vec(v, e);
    w = 0;
    while (!out_valid && w < 400) begin tick(1); w++; end
    chk("abort_out_wait", out_valid, 1'b1);
    abort = 1'b1;
    out_ready = 1'b1;
    tick(1);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_out_valid_drop", out_valid, 1'b0);
    chk("abort_out_busy", busy, 1'b0);
    chk("abort_out_data_kept", out_data, e);
    tick(2);

    v = rvec(4096);
    send_vec(v, model(v));
    wait_done();
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
